// File: rtl/core_mem_bridge_pkg.sv
// core_pkg: shared definitions for the core/memory load-store bridge.
//   - access size encodings SZ_B/SZ_H/SZ_W/SZ_D
//   - bridge FSM state enum
//   - misaligned(): alignment check of an access against its size
// No ports; imported by core_mem_bridge and mem_lane_align.
package core_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RESP = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  // True when the low address bits are not a multiple of the access size.
  function automatic logic misaligned(input logic [2:0] addr_lsbs, input logic [1:0] size);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = addr_lsbs[0];
      SZ_W:    mis = |addr_lsbs[1:0];
      SZ_D:    mis = |addr_lsbs[2:0];
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/core_mem_bridge_if.sv
// core_mem_bridge_if: ready/valid memory bus between the bridge and memory.
// Parameters: ADDR_W address width, DATA_W data width (32 or 64).
// Signals:
//   mem_valid/mem_ready    request handshake
//   mem_we                 store qualifier
//   mem_addr               word-aligned address
//   mem_wdata/mem_wstrb    lane-replicated store data and byte enables
//   mem_rvalid/mem_rdata   load response
// Modports: master (bridge side), slave (memory side).
interface core_mem_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  mem_valid;
  logic                  mem_ready;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: purely combinational lane steering for the bridge.
// Ports:
//   size_i, unsigned_i, we_i, lane_i   access descriptor
//   wdata_i   right-aligned store data  -> wdata_o replicated into every lane
//   wstrb_o   byte enables (all ones for loads)
//   rdata_i   raw bus word              -> rdata_o lane extracted and extended
module mem_lane_align
  import core_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANE_W = $clog2(DATA_W/8)
) (
  input  logic [1:0]          size_i,
  input  logic                unsigned_i,
  input  logic                we_i,
  input  logic [LANE_W-1:0]   lane_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W-1:0]   rdata_i,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic [DATA_W-1:0]   rdata_o
);

  localparam int NB = DATA_W/8;

  logic [DATA_W-1:0] shifted_s;
  logic              sign_s;
  int                nbytes_s;
  int                nbits_s;

  // Store side: replicate the low bytes of the store data across the bus
  // so that whichever lane is strobed carries the right bytes.
  always_comb begin
    wdata_o  = {DATA_W{1'b0}};
    wstrb_o  = {NB{1'b0}};
    nbytes_s = 1 << size_i;
    for (int i = 0; i < NB; i++) begin
      case (size_i)
        SZ_B:    wdata_o[8*i +: 8] = wdata_i[7:0];
        SZ_H:    wdata_o[8*i +: 8] = wdata_i[8*(i%2) +: 8];
        SZ_W:    wdata_o[8*i +: 8] = wdata_i[8*(i%4) +: 8];
        default: wdata_o[8*i +: 8] = wdata_i[8*i +: 8];
      endcase
      if (we_i) begin
        wstrb_o[i] = (i >= int'(lane_i)) && (i < int'(lane_i) + nbytes_s);
      end else begin
        wstrb_o[i] = 1'b1;
      end
    end
  end

  // Load side: move the addressed lane to bit 0, then extend above the access width.
  always_comb begin
    rdata_o   = {DATA_W{1'b0}};
    shifted_s = rdata_i >> {lane_i, 3'b000};
    nbits_s   = 8 << size_i;
    case (size_i)
      SZ_B:    sign_s = shifted_s[7];
      SZ_H:    sign_s = shifted_s[15];
      SZ_W:    sign_s = shifted_s[31];
      default: sign_s = shifted_s[DATA_W-1];
    endcase
    for (int i = 0; i < DATA_W; i++) begin
      if (i < nbits_s) begin
        rdata_o[i] = shifted_s[i];
      end else if (unsigned_i) begin
        rdata_o[i] = 1'b0;
      end else begin
        rdata_o[i] = sign_s;
      end
    end
  end

endmodule

// File: rtl/core_mem_bridge.sv
// core_mem_bridge: registered load/store bridge from the multicycle core to a
// ready/valid memory bus. The request is latched when accepted in IDLE, so the
// core may drop its inputs; the core is stalled via core_busy until core_done.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   core_req/we/size/unsigned/addr/wdata   core request
//   core_busy, core_done, core_err, core_rdata   core status / load result
//   mem                        core_mem_bridge_if.master bus port
// Optional build macro CORE_MEM_TIMEOUT_EN: response watchdog that ends a
// stuck access with core_err after TIMEOUT_CYCLES cycles in REQ/RESP.
module core_mem_bridge
  import core_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                core_req,
  input  logic                core_we,
  input  logic [1:0]          core_size,
  input  logic                core_unsigned,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  output logic                core_busy,
  output logic                core_done,
  output logic                core_err,
  output logic [DATA_W-1:0]   core_rdata,
  core_mem_bridge_if.master   mem
);

  localparam int NB     = DATA_W/8;
  localparam int LANE_W = $clog2(NB);

  if ((DATA_W != 32 && DATA_W != 64) || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("core_mem_bridge: DATA_W must be 32 or 64 and TIMEOUT_CYCLES at least 2");
  end

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                valid_q, valid_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]       wstrb_q, wstrb_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [LANE_W-1:0]   lane_q, lane_d;

  logic [1:0]          al_size;
  logic                al_uns;
  logic [LANE_W-1:0]   al_lane;
  logic [DATA_W-1:0]   al_wdata;
  logic [NB-1:0]       al_wstrb;
  logic [DATA_W-1:0]   al_rdata;
  logic                req_mis;
  logic                timeout;

  // In IDLE the aligner sees the live core request (store data is registered
  // on accept); afterwards it sees the latched descriptor for the load return.
  assign al_size = (state_q == IDLE) ? core_size              : size_q;
  assign al_uns  = (state_q == IDLE) ? core_unsigned          : uns_q;
  assign al_lane = (state_q == IDLE) ? core_addr[LANE_W-1:0]  : lane_q;

  mem_lane_align #(.DATA_W(DATA_W), .LANE_W(LANE_W)) u_align (
    .size_i     (al_size),
    .unsigned_i (al_uns),
    .we_i       (core_we),
    .lane_i     (al_lane),
    .wdata_i    (core_wdata),
    .rdata_i    (mem.mem_rdata),
    .wdata_o    (al_wdata),
    .wstrb_o    (al_wstrb),
    .rdata_o    (al_rdata)
  );

  // Double accesses only exist on a 64-bit bus.
  assign req_mis = misaligned(core_addr[2:0], core_size) ||
                   ((core_size == SZ_D) && (DATA_W != 64));

`ifdef CORE_MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog count: cleared on REQ entry, advancing in REQ and RESP.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d == REQ) && (state_q != REQ)) begin
      cnt_d = {CNT_W{1'b0}};
    end else if ((state_q == REQ) || (state_q == RESP)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state logic; outputs are derived from the next state so that every
  // output register lines up with the state it belongs to.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    size_d  = size_q;
    uns_d   = uns_q;
    lane_d  = lane_q;
    case (state_q)
      IDLE: begin
        if (core_req) begin
          we_d    = core_we;
          addr_d  = {core_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
          wdata_d = al_wdata;
          wstrb_d = al_wstrb;
          size_d  = core_size;
          uns_d   = core_unsigned;
          lane_d  = core_addr[LANE_W-1:0];
          if (req_mis) begin
            state_d = ERR;
          end else begin
            state_d = REQ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem.mem_ready) begin
          if (we_q) begin
            state_d = DONE;
          end else begin
            state_d = RESP;
          end
        end else if (timeout) begin
          state_d = ERR;
        end else begin
          state_d = REQ;
        end
      end
      RESP: begin
        if (mem.mem_rvalid) begin
          rdata_d = al_rdata;
          state_d = DONE;
        end else if (timeout) begin
          state_d = ERR;
        end else begin
          state_d = RESP;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == REQ);
    done_d  = (state_d == DONE) || (state_d == ERR);
    err_d   = (state_d == ERR);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= {DATA_W{1'b0}};
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      wstrb_q <= {NB{1'b0}};
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      lane_q  <= {LANE_W{1'b0}};
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      lane_q  <= lane_d;
    end
  end

  assign core_busy     = busy_q;
  assign core_done     = done_q;
  assign core_err      = err_q;
  assign core_rdata    = rdata_q;
  assign mem.mem_valid = valid_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_core_mem_bridge.sv
// tb_core_mem_bridge: directed self-checking bench for core_mem_bridge
// (DATA_W=32, TIMEOUT_CYCLES=8). Inputs change and outputs are sampled on the
// falling clock edge. The watchdog scenario is included when the bench is
// built with CORE_MEM_TIMEOUT_EN.
module tb_core_mem_bridge;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_req = 1'b0;
  logic        core_we = 1'b0;
  logic [1:0]  core_size = 2'b00;
  logic        core_unsigned = 1'b0;
  logic [31:0] core_addr = 32'h0;
  logic [31:0] core_wdata = 32'h0;
  logic        core_busy;
  logic        core_done;
  logic        core_err;
  logic [31:0] core_rdata;

  int n_checks = 0;
  int n_errors = 0;

  core_mem_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  core_mem_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .core_req      (core_req),
    .core_we       (core_we),
    .core_size     (core_size),
    .core_unsigned (core_unsigned),
    .core_addr     (core_addr),
    .core_wdata    (core_wdata),
    .core_busy     (core_busy),
    .core_done     (core_done),
    .core_err      (core_err),
    .core_rdata    (core_rdata),
    .mem           (bus)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present a one-cycle request at the current falling edge; returns one cycle later.
  task automatic start_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd);
    core_req      = 1'b1;
    core_we       = we;
    core_size     = sz;
    core_unsigned = uns;
    core_addr     = addr;
    core_wdata    = wd;
    @(negedge clk);
    core_req      = 1'b0;
    core_wdata    = 32'h0;
  endtask

  task automatic check_idle_zero(input string tag);
    check_value({tag, "_busy"},  64'(core_busy),      64'h0);
    check_value({tag, "_done"},  64'(core_done),      64'h0);
    check_value({tag, "_err"},   64'(core_err),       64'h0);
    check_value({tag, "_rdata"}, 64'(core_rdata),     64'h0);
    check_value({tag, "_valid"}, 64'(bus.mem_valid),  64'h0);
    check_value({tag, "_we"},    64'(bus.mem_we),     64'h0);
    check_value({tag, "_addr"},  64'(bus.mem_addr),   64'h0);
    check_value({tag, "_wdata"}, 64'(bus.mem_wdata),  64'h0);
    check_value({tag, "_wstrb"}, 64'(bus.mem_wstrb),  64'h0);
  endtask

  task automatic store_vec(input string tag, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp_addr,
                           input logic [31:0] exp_wdata, input logic [3:0] exp_strb);
    bus.mem_ready = 1'b1;
    start_req(1'b1, sz, 1'b0, addr, wd);
    check_value({tag, "_valid"}, 64'(bus.mem_valid), 64'h1);
    check_value({tag, "_we"},    64'(bus.mem_we),    64'h1);
    check_value({tag, "_addr"},  64'(bus.mem_addr),  64'(exp_addr));
    check_value({tag, "_wdata"}, 64'(bus.mem_wdata), 64'(exp_wdata));
    check_value({tag, "_wstrb"}, 64'(bus.mem_wstrb), 64'(exp_strb));
    check_value({tag, "_done1"}, 64'(core_done),     64'h0);
    @(negedge clk);
    check_value({tag, "_done2"}, 64'(core_done),     64'h1);
    check_value({tag, "_err"},   64'(core_err),      64'h0);
    check_value({tag, "_vld2"},  64'(bus.mem_valid), 64'h0);
    @(negedge clk);
    check_value({tag, "_done3"}, 64'(core_done),     64'h0);
    check_value({tag, "_busy3"}, 64'(core_busy),     64'h0);
  endtask

  task automatic load_vec(input string tag, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] raw,
                          input logic [31:0] exp_addr, input logic [31:0] exp_rdata);
    bus.mem_ready = 1'b1;
    start_req(1'b0, sz, uns, addr, 32'h0);
    check_value({tag, "_valid"}, 64'(bus.mem_valid), 64'h1);
    check_value({tag, "_we"},    64'(bus.mem_we),    64'h0);
    check_value({tag, "_addr"},  64'(bus.mem_addr),  64'(exp_addr));
    check_value({tag, "_wstrb"}, 64'(bus.mem_wstrb), 64'hF);
    @(negedge clk);
    check_value({tag, "_done2"}, 64'(core_done),     64'h0);
    check_value({tag, "_busy2"}, 64'(core_busy),     64'h1);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = raw;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    check_value({tag, "_done3"}, 64'(core_done),     64'h1);
    check_value({tag, "_err"},   64'(core_err),      64'h0);
    check_value({tag, "_rdata"}, 64'(core_rdata),    64'(exp_rdata));
    @(negedge clk);
    check_value({tag, "_done4"}, 64'(core_done),     64'h0);
    check_value({tag, "_hold"},  64'(core_rdata),    64'(exp_rdata));
  endtask

  task automatic err_vec(input string tag, input logic [1:0] sz, input logic [31:0] addr);
    bus.mem_ready = 1'b1;
    start_req(1'b0, sz, 1'b0, addr, 32'h0);
    check_value({tag, "_done"},  64'(core_done),     64'h1);
    check_value({tag, "_err"},   64'(core_err),      64'h1);
    check_value({tag, "_valid"}, 64'(bus.mem_valid), 64'h0);
    @(negedge clk);
    check_value({tag, "_done2"}, 64'(core_done),     64'h0);
    check_value({tag, "_busy2"}, 64'(core_busy),     64'h0);
    check_value({tag, "_vld2"},  64'(bus.mem_valid), 64'h0);
  endtask

  initial begin
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("reset");

    // Stores: lane replication and strobes
    store_vec("st_w",   SZ_W, 32'h100, 32'hDEADBEEF, 32'h100, 32'hDEADBEEF, 4'b1111);
    store_vec("st_b2",  SZ_B, 32'h102, 32'h000000A5, 32'h100, 32'hA5A5A5A5, 4'b0100);
    store_vec("st_h2",  SZ_H, 32'h102, 32'h00001234, 32'h100, 32'h12341234, 4'b1100);
    store_vec("st_b7",  SZ_B, 32'h107, 32'h0000003C, 32'h104, 32'h3C3C3C3C, 4'b1000);

    // Loads: extraction and extension
    load_vec("ld_bs",  SZ_B, 1'b0, 32'h103, 32'h80000000, 32'h100, 32'hFFFFFF80);
    load_vec("ld_bu",  SZ_B, 1'b1, 32'h103, 32'h80000000, 32'h100, 32'h00000080);
    load_vec("ld_hs",  SZ_H, 1'b0, 32'h102, 32'h80010000, 32'h100, 32'hFFFF8001);
    load_vec("ld_hu",  SZ_H, 1'b1, 32'h100, 32'h1234F00F, 32'h100, 32'h0000F00F);
    load_vec("ld_w",   SZ_W, 1'b0, 32'h104, 32'h12345678, 32'h104, 32'h12345678);
    load_vec("ld_b1",  SZ_B, 1'b0, 32'h101, 32'h00007F00, 32'h100, 32'h0000007F);

    // Misaligned and illegal sizes
    err_vec("mis_h", SZ_H, 32'h101);
    err_vec("mis_w", SZ_W, 32'h102);
    err_vec("mis_d", SZ_D, 32'h100);

    // Stalled bus: five wait cycles with mem_ready low
    bus.mem_ready = 1'b0;
    start_req(1'b1, SZ_W, 1'b0, 32'h200, 32'hCAFEF00D);
    for (int i = 1; i <= 6; i++) begin
      check_value("stall_valid", 64'(bus.mem_valid), 64'h1);
      check_value("stall_busy",  64'(core_busy),     64'h1);
      check_value("stall_done",  64'(core_done),     64'h0);
      check_value("stall_addr",  64'(bus.mem_addr),  64'h200);
      check_value("stall_wdata", 64'(bus.mem_wdata), 64'hCAFEF00D);
      check_value("stall_wstrb", 64'(bus.mem_wstrb), 64'hF);
      if (i == 6) begin
        bus.mem_ready = 1'b1;
      end
      @(negedge clk);
    end
    check_value("stall_done_end", 64'(core_done), 64'h1);
    check_value("stall_err_end",  64'(core_err),  64'h0);
    @(negedge clk);

    // Reset while waiting in RESP, followed by a late response
    bus.mem_ready = 1'b1;
    start_req(1'b0, SZ_W, 1'b0, 32'h100, 32'h0);
    @(negedge clk);
    check_value("rst_in_resp_busy", 64'(core_busy), 64'h1);
    rst = 1'b1;
    @(negedge clk);
    rst            = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h55AA55AA;
    check_idle_zero("rst_mid");
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    check_idle_zero("rst_late");

    // Back-to-back: request held high is accepted again in the IDLE cycle after done
    bus.mem_ready = 1'b1;
    core_req      = 1'b1;
    core_we       = 1'b1;
    core_size     = SZ_W;
    core_addr     = 32'h300;
    core_wdata    = 32'h11111111;
    @(negedge clk);
    core_addr     = 32'h304;
    core_wdata    = 32'h22222222;
    check_value("b2b_addr1", 64'(bus.mem_addr),  64'h300);
    check_value("b2b_wd1",   64'(bus.mem_wdata), 64'h11111111);
    @(negedge clk);
    check_value("b2b_done1", 64'(core_done), 64'h1);
    @(negedge clk);
    check_value("b2b_idle",  64'(core_busy), 64'h0);
    @(negedge clk);
    core_req = 1'b0;
    check_value("b2b_valid2", 64'(bus.mem_valid), 64'h1);
    check_value("b2b_addr2",  64'(bus.mem_addr),  64'h304);
    check_value("b2b_wd2",    64'(bus.mem_wdata), 64'h22222222);
    @(negedge clk);
    check_value("b2b_done2", 64'(core_done), 64'h1);
    @(negedge clk);

`ifdef CORE_MEM_TIMEOUT_EN
    // Watchdog: REQ entered at cycle 1, error completion 8 cycles later
    bus.mem_ready = 1'b0;
    start_req(1'b1, SZ_W, 1'b0, 32'h400, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      check_value("to_wait_done",  64'(core_done),     64'h0);
      check_value("to_wait_valid", 64'(bus.mem_valid), 64'h1);
      @(negedge clk);
    end
    check_value("to_done",  64'(core_done),     64'h1);
    check_value("to_err",   64'(core_err),      64'h1);
    check_value("to_valid", 64'(bus.mem_valid), 64'h0);
    @(negedge clk);
    check_value("to_idle",  64'(core_busy),     64'h0);
    check_value("to_done2", 64'(core_done),     64'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
